// File: rtl/fabric_mem_load_port_pkg.sv
// Shared definitions for the fabric memory load port.
//   load_status_e   : marks whether a captured load was in range or out of range
//   MIN_QUEUE_DEPTH : smallest response queue the credit scheme can work with
//   idx_width()     : SRAM word-index width, never narrower than one bit
//   count_width()   : width of a counter that must reach the full depth value
package fabric_mem_load_port_pkg;

  typedef enum logic {
    LOAD_OK  = 1'b0,
    LOAD_OOB = 1'b1
  } load_status_e;

  localparam int MIN_QUEUE_DEPTH = 2;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fabric_mem_load_port_if.sv
// Bus bundle for the load port: request channel, response channel and the
// SRAM read port.
//   req_valid/req_ready/req_data    : load request {tag, address}
//   resp_valid/resp_ready/resp_data : load response {tag, element}
//   mem_rd_en/mem_rd_addr           : SRAM read strobe and word index
//   mem_rd_data                     : SRAM data, one cycle after mem_rd_en
// The master modport is the requester/memory side, the slave modport is the
// load port itself.
interface fabric_mem_load_port_if
  import fabric_mem_load_port_pkg::*;
#(
  parameter int ELEM_WIDTH = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int TAG_WIDTH  = 0,
  parameter int MEM_DEPTH  = 256
);

  localparam int IDX_W = idx_width(MEM_DEPTH);

  logic                            req_valid;
  logic                            req_ready;
  logic [ADDR_WIDTH+TAG_WIDTH-1:0] req_data;
  logic                            resp_valid;
  logic                            resp_ready;
  logic [ELEM_WIDTH+TAG_WIDTH-1:0] resp_data;
  logic                            mem_rd_en;
  logic [IDX_W-1:0]                mem_rd_addr;
  logic [ELEM_WIDTH-1:0]           mem_rd_data;

  modport master (
    output req_valid, req_data, resp_ready, mem_rd_data,
    input  req_ready, resp_valid, resp_data, mem_rd_en, mem_rd_addr
  );

  modport slave (
    input  req_valid, req_data, resp_ready, mem_rd_data,
    output req_ready, resp_valid, resp_data, mem_rd_en, mem_rd_addr
  );

endinterface

// File: rtl/fabric_mem_load_port_fifo.sv
// fabric_sync_fifo: synchronous FIFO used as the load response queue.
//   clk, rst : clock and synchronous active-high reset
//   wr_en    : push wr_data (ignored when full unless a pop happens too)
//   rd_en    : pop the head (ignored when empty)
//   rd_data  : current head entry
//   count    : number of stored entries, 0..DEPTH
// Pointers wrap explicitly at DEPTH so non-power-of-two depths work.
module fabric_sync_fifo
  import fabric_mem_load_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // A pop frees the slot in the same cycle, so a push into a full queue is
  // accepted when it coincides with a pop.
  assign do_rd   = rd_en && (count != '0);
  assign do_wr   = wr_en && ((count != CNT_W'(DEPTH)) || do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      if (do_wr && !do_rd)      count <= count + CNT_W'(1);
      else if (!do_wr && do_rd) count <= count - CNT_W'(1);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fabric_mem_load_port.sv
// fabric_mem_load_port: turns {tag, address} load requests into SRAM reads
// and returns {tag, element} responses in request order.
//   clk, rst : clock and synchronous active-high reset
//   bus      : request, response and SRAM read channels (slave modport)
//   err_oob  : sticky flag, set by any request at or beyond MEM_DEPTH
// Out-of-range requests skip the SRAM and return a zero element. The credit
// counter tracks queued plus in-flight loads, so a queue slot always exists
// for every load that has been accepted.
module fabric_mem_load_port
  import fabric_mem_load_port_pkg::*;
#(
  parameter int ELEM_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 64,
  parameter int TAG_WIDTH   = 0,
  parameter int MEM_DEPTH   = 256,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fabric_mem_load_port_if.slave bus,
  output logic                  err_oob
);

  localparam int IDX_W   = idx_width(MEM_DEPTH);
  localparam int ENTRY_W = ELEM_WIDTH + TAG_WIDTH;
  localparam int CNT_W   = count_width(QUEUE_DEPTH);
  // Wide enough to hold both any address and MEM_DEPTH itself.
  localparam int CMP_W   = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 33;

  if (ELEM_WIDTH < 1 || ADDR_WIDTH < 1 || MEM_DEPTH < 1 ||
      QUEUE_DEPTH < MIN_QUEUE_DEPTH) begin : g_bad_params
    $fatal(1, "fabric_mem_load_port: illegal parameter combination");
  end

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [CMP_W-1:0]      req_addr_ext;
  logic                  in_range;
  logic                  fire;
  logic                  pop;
  logic [CNT_W-1:0]      credit_q;
  logic                  inflight_valid_q;
  load_status_e          inflight_status_q;
  logic [ELEM_WIDTH-1:0] load_elem;
  logic [ENTRY_W-1:0]    fifo_wr_data;
  logic [CNT_W-1:0]      fifo_count;

  assign req_addr     = bus.req_data[ADDR_WIDTH-1:0];
  assign req_addr_ext = CMP_W'(req_addr);
  assign in_range     = req_addr_ext < CMP_W'(MEM_DEPTH);

  // Readiness depends only on the credit register (and reset), never on
  // resp_ready or req_valid.
  assign bus.req_ready   = !rst && (credit_q < CNT_W'(QUEUE_DEPTH));
  assign fire            = bus.req_valid && bus.req_ready;
  assign bus.mem_rd_en   = fire && in_range;
  assign bus.mem_rd_addr = bus.mem_rd_en ? IDX_W'(req_addr) : '0;

  assign bus.resp_valid = (fifo_count != '0);
  assign pop            = bus.resp_valid && bus.resp_ready;

  // Credit counter, one-stage in-flight register and the sticky OOB flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q          <= '0;
      inflight_valid_q  <= 1'b0;
      inflight_status_q <= LOAD_OK;
      err_oob           <= 1'b0;
    end else begin
      inflight_valid_q  <= fire;
      inflight_status_q <= in_range ? LOAD_OK : LOAD_OOB;
      if (fire && !in_range) err_oob <= 1'b1;
      if (fire && !pop)      credit_q <= credit_q + CNT_W'(1);
      else if (!fire && pop) credit_q <= credit_q - CNT_W'(1);
    end
  end

  // SRAM data arrives alongside the in-flight entry; OOB loads return zero.
  assign load_elem = (inflight_status_q == LOAD_OOB) ? '0 : bus.mem_rd_data;

  if (TAG_WIDTH > 0) begin : g_tag
    logic [TAG_WIDTH-1:0] inflight_tag_q;

    // The tag travels with the load through the in-flight stage.
    always_ff @(posedge clk) begin
      if (rst)       inflight_tag_q <= '0;
      else if (fire) inflight_tag_q <= bus.req_data[ADDR_WIDTH +: TAG_WIDTH];
    end

    assign fifo_wr_data = {inflight_tag_q, load_elem};
  end else begin : g_no_tag
    assign fifo_wr_data = load_elem;
  end

  fabric_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_resp_queue (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_valid_q),
    .wr_data (fifo_wr_data),
    .rd_en   (pop),
    .rd_data (bus.resp_data),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_fabric_mem_load_port.sv
// Testbench for fabric_mem_load_port (TAG_WIDTH=4, ADDR_WIDTH=16,
// MEM_DEPTH=256, QUEUE_DEPTH=4). The SRAM is a behavioural array that
// returns random garbage whenever no read was strobed. Expected responses
// come from the request log: {tag, addr < 256 ? sram[addr] : 0}.
module tb_fabric_mem_load_port;

  logic clk;
  logic rst;
  logic err_oob;

  fabric_mem_load_port_if #(
    .ELEM_WIDTH (32), .ADDR_WIDTH (16), .TAG_WIDTH (4), .MEM_DEPTH (256)
  ) bus ();

  fabric_mem_load_port #(
    .ELEM_WIDTH (32), .ADDR_WIDTH (16), .TAG_WIDTH (4),
    .MEM_DEPTH (256), .QUEUE_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_oob (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sram [256];

  // SRAM model: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= sram[bus.mem_rd_addr];
    else               bus.mem_rd_data <= $urandom();
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic        s_ready, s_fire, s_rd_en, s_resp_valid, s_err;
  logic [7:0]  s_rd_addr;
  logic [35:0] s_resp_data;

  logic [19:0] req_q[$];
  int          req_cyc_q[$];
  logic [35:0] resp_q[$];
  int          resp_cyc_q[$];

  function automatic logic [35:0] model_resp(input logic [19:0] req);
    logic [15:0] a;
    a = req[15:0];
    if (a < 16'd256) return {req[19:16], sram[a[7:0]]};
    return {req[19:16], 32'h0};
  endfunction

  // One clock cycle: sample everything mid-cycle, log accepted requests and
  // delivered responses, then move on to the next falling edge.
  task automatic tick();
    #1;
    s_ready      = bus.req_ready;
    s_fire       = bus.req_valid && bus.req_ready;
    s_rd_en      = bus.mem_rd_en;
    s_rd_addr    = bus.mem_rd_addr;
    s_resp_valid = bus.resp_valid;
    s_resp_data  = bus.resp_data;
    s_err        = err_oob;
    if (s_fire) begin
      req_q.push_back(bus.req_data);
      req_cyc_q.push_back(cyc);
    end
    if (bus.resp_valid && bus.resp_ready) begin
      resp_q.push_back(bus.resp_data);
      resp_cyc_q.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    req_q.delete(); req_cyc_q.delete(); resp_q.delete(); resp_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req_valid = 1'b1; bus.req_data = {4'h1, 16'd7}; bus.resp_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req_ready: got %b want 0", s_ready); end
    n_cmp++; if (s_rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_rd_en: got %b want 0", s_rd_en); end
    n_cmp++; if (s_rd_addr !== 8'h0) begin n_fail++; $display("[TB] FAIL rst_mem_rd_addr: got %h want 0", s_rd_addr); end
    n_cmp++; if (s_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_resp_valid: got %b want 0", s_resp_valid); end
    n_cmp++; if (s_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_err_oob: got %b want 0", s_err); end
    rst = 1'b0; bus.req_valid = 1'b0;
    tick();
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_single();
    clear_logs();
    bus.resp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_data = {4'h3, 16'd5};
    tick();
    n_cmp++; if (s_rd_en !== 1'b1) begin n_fail++; $display("[TB] FAIL single_rd_en: got %b want 1", s_rd_en); end
    n_cmp++; if (s_rd_addr !== 8'd5) begin n_fail++; $display("[TB] FAIL single_rd_addr: got %h want 05", s_rd_addr); end
    bus.req_valid = 1'b0;
    tick();
    n_cmp++; if (s_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_valid: got %b want 0", s_resp_valid); end
    tick();
    n_cmp++; if (s_resp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid_n2: got %b want 1", s_resp_valid); end
    n_cmp++; if (s_resp_data !== {4'h3, 32'hDEADBEEF}) begin n_fail++; $display("[TB] FAIL single_data: got %h want 3deadbeef", s_resp_data); end
    n_cmp++; if (s_err !== 1'b0) begin n_fail++; $display("[TB] FAIL single_err: got %b want 0", s_err); end
    tick();
    n_cmp++; if (s_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_valid_after_pop: got %b want 0", s_resp_valid); end
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    clear_logs();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.req_valid = 1'b1; bus.req_data = {4'(i), 16'(i)};
      tick();
      if (!s_ready) drops++;
    end
    bus.req_valid = 1'b0;
    for (int k = 0; k < 20 && resp_q.size() < 16; k++) tick();
    n_cmp++; if (drops !== 0) begin n_fail++; $display("[TB] FAIL b2b_ready_drops: got %0d want 0", drops); end
    n_cmp++; if (resp_q.size() !== 16) begin n_fail++; $display("[TB] FAIL b2b_resp_count: got %0d want 16", resp_q.size()); end
    for (int i = 0; i < resp_q.size() && i < req_q.size(); i++) begin
      n_cmp++; if (resp_q[i] !== model_resp(req_q[i])) begin n_fail++; $display("[TB] FAIL b2b_data[%0d]: got %h want %h", i, resp_q[i], model_resp(req_q[i])); end
    end
    if (resp_q.size() == 16) begin
      n_cmp++; if (resp_cyc_q[15] - resp_cyc_q[0] !== 15) begin n_fail++; $display("[TB] FAIL b2b_consecutive: span %0d want 15", resp_cyc_q[15] - resp_cyc_q[0]); end
      n_cmp++; if (resp_cyc_q[0] - req_cyc_q[0] !== 2) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d want 2", resp_cyc_q[0] - req_cyc_q[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] held;
    logic        have_held = 1'b0;
    clear_logs();
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1; bus.req_data = {4'(i + 8), 16'($urandom_range(0, 255))};
      tick();
      if (s_resp_valid && !have_held) begin held = s_resp_data; have_held = 1'b1; end
    end
    n_cmp++; if (req_q.size() !== 4) begin n_fail++; $display("[TB] FAIL bp_accepted: got %0d want 4", req_q.size()); end
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_full: got %b want 0", s_ready); end
    n_cmp++; if ({s_resp_valid, s_resp_data} !== {have_held, held}) begin n_fail++; $display("[TB] FAIL bp_hold: got %b/%h want %b/%h", s_resp_valid, s_resp_data, have_held, held); end
    bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
    for (int k = 0; k < 10 && resp_q.size() < 4; k++) tick();
    n_cmp++; if (resp_q.size() !== 4) begin n_fail++; $display("[TB] FAIL bp_resp_count: got %0d want 4", resp_q.size()); end
    for (int i = 0; i < resp_q.size() && i < req_q.size(); i++) begin
      n_cmp++; if (resp_q[i] !== model_resp(req_q[i])) begin n_fail++; $display("[TB] FAIL bp_data[%0d]: got %h want %h", i, resp_q[i], model_resp(req_q[i])); end
    end
  endtask

  task automatic test_oob();
    clear_logs();
    bus.resp_ready = 1'b1; bus.req_valid = 1'b1;
    bus.req_data = {4'hA, 16'd300};
    tick();
    n_cmp++; if (s_rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL oob_rd_en: got %b want 0", s_rd_en); end
    n_cmp++; if (s_err !== 1'b0) begin n_fail++; $display("[TB] FAIL oob_err_cycle_n: got %b want 0", s_err); end
    bus.req_data = {4'h5, 16'd255};
    tick();
    n_cmp++; if (s_err !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_err_n1: got %b want 1", s_err); end
    n_cmp++; if ({s_rd_en, s_rd_addr} !== {1'b1, 8'd255}) begin n_fail++; $display("[TB] FAIL oob_edge_255: got %b/%h want 1/ff", s_rd_en, s_rd_addr); end
    bus.req_data = {4'h6, 16'd256};
    tick();
    n_cmp++; if (s_rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL oob_edge_256: got %b want 0", s_rd_en); end
    bus.req_valid = 1'b0;
    for (int k = 0; k < 10 && resp_q.size() < 3; k++) tick();
    n_cmp++; if (resp_q.size() !== 3) begin n_fail++; $display("[TB] FAIL oob_resp_count: got %0d want 3", resp_q.size()); end
    for (int i = 0; i < resp_q.size() && i < req_q.size(); i++) begin
      n_cmp++; if (resp_q[i] !== model_resp(req_q[i])) begin n_fail++; $display("[TB] FAIL oob_data[%0d]: got %h want %h", i, resp_q[i], model_resp(req_q[i])); end
    end
    repeat (5) tick();
    n_cmp++; if (s_err !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_sticky: got %b want 1", s_err); end
  endtask

  task automatic test_reset_mid_flight();
    clear_logs();
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1; bus.req_data = {4'(i + 1), 16'($urandom_range(0, 255))};
      tick();
    end
    n_cmp++; if (req_q.size() !== 3) begin n_fail++; $display("[TB] FAIL rmf_accepted: got %0d want 3", req_q.size()); end
    bus.req_valid = 1'b0; rst = 1'b1;
    tick();
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rmf_ready_in_rst: got %b want 0", s_ready); end
    rst = 1'b0; bus.resp_ready = 1'b1;
    tick();
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmf_ready_after: got %b want 1", s_ready); end
    n_cmp++; if (s_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rmf_err_cleared: got %b want 0", s_err); end
    repeat (8) tick();
    n_cmp++; if (resp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL rmf_stale_resp: got %0d want 0", resp_q.size()); end
  endtask

  task automatic test_random();
    int          occ;
    logic        exp_err    = 1'b0;
    logic        stall_prev = 1'b0;
    logic [35:0] prev_data  = '0;
    logic [19:0] d;
    clear_logs();
    for (int c = 0; c < 20000 && req_q.size() < 1000; c++) begin
      d = {4'($urandom()), 16'($urandom_range(0, 299))};
      bus.req_data   = d;
      bus.req_valid  = ($urandom_range(0, 9) < 6);
      bus.resp_ready = ($urandom_range(0, 9) < 7);
      occ = req_q.size() - resp_q.size();
      tick();
      n_cmp++; if (s_ready !== (occ < 4)) begin n_fail++; $display("[TB] FAIL rnd_ready@%0d: got %b want %b (occ %0d)", cyc, s_ready, occ < 4, occ); end
      n_cmp++; if (s_err !== exp_err) begin n_fail++; $display("[TB] FAIL rnd_err@%0d: got %b want %b", cyc, s_err, exp_err); end
      if (s_fire) begin
        n_cmp++; if (s_rd_en !== (d[15:0] < 16'd256)) begin n_fail++; $display("[TB] FAIL rnd_rd_en@%0d: got %b addr %0d", cyc, s_rd_en, d[15:0]); end
        if (d[15:0] < 16'd256) begin
          n_cmp++; if (s_rd_addr !== d[7:0]) begin n_fail++; $display("[TB] FAIL rnd_rd_addr@%0d: got %h want %h", cyc, s_rd_addr, d[7:0]); end
        end else exp_err = 1'b1;
      end
      if (stall_prev) begin
        n_cmp++; if ({s_resp_valid, s_resp_data} !== {1'b1, prev_data}) begin n_fail++; $display("[TB] FAIL rnd_hold@%0d: got %b/%h want 1/%h", cyc, s_resp_valid, s_resp_data, prev_data); end
      end
      stall_prev = s_resp_valid && !bus.resp_ready;
      prev_data  = s_resp_data;
    end
    n_cmp++; if (req_q.size() !== 1000) begin n_fail++; $display("[TB] FAIL rnd_accept_timeout: got %0d want 1000", req_q.size()); end
    bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
    for (int k = 0; k < 50 && resp_q.size() < req_q.size(); k++) tick();
    repeat (3) tick();
    n_cmp++; if (resp_q.size() !== req_q.size()) begin n_fail++; $display("[TB] FAIL rnd_resp_count: got %0d want %0d", resp_q.size(), req_q.size()); end
    for (int i = 0; i < resp_q.size() && i < req_q.size(); i++) begin
      n_cmp++; if (resp_q[i] !== model_resp(req_q[i])) begin n_fail++; $display("[TB] FAIL rnd_data[%0d]: got %h want %h", i, resp_q[i], model_resp(req_q[i])); end
      n_cmp++; if (resp_cyc_q[i] - req_cyc_q[i] < 2) begin n_fail++; $display("[TB] FAIL rnd_latency[%0d]: got %0d want >=2", i, resp_cyc_q[i] - req_cyc_q[i]); end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; bus.req_valid = 1'b0; bus.req_data = '0; bus.resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) sram[i] = $urandom();
    sram[5] = 32'hDEADBEEF;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_oob();
    test_reset_mid_flight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
